qpu_itcm_ctrl: RTL and testbench
================================

// Module: qpu_itcm_ctrl
// PURPOSE
//  ICB responder for the ITCM: serves IFU fetch port (read-only) and EXT loader port (read/write).
//  Round-robin arbiter into one 1RW SRAM. 1-cycle read latency; per-port response hold.
//  Drives itcm_nohold back to the IFU.
// PARAMETERS
//  AW      16   byte-address width (= `QPU_ITCM_ADDR_WIDTH)
//  DW      64   data width (= `QPU_ITCM_DATA_WIDTH); word index = addr[AW-1:$clog2(DW/8)]
//  DEPTH   2**(AW-$clog2(DW/8))  SRAM words; words at or above DEPTH are out of range
// PORTS
//  clk             in   1      clock; all state on posedge
//  rst             in   1      synchronous reset, active-high
//  ifu_cmd_valid   in   1      IFU fetch request
//  ifu_cmd_ready   out  1      IFU request accepted when valid&ready
//  ifu_cmd_addr    in   AW     fetch byte address
//  ifu_rsp_valid   out  1      fetch data valid
//  ifu_rsp_ready   in   1      IFU consumes response
//  ifu_rsp_rdata   out  DW     fetched word
//  ifu_rsp_err     out  1      address out of range
//  ext_cmd_valid   in   1      loader request
//  ext_cmd_ready   out  1      loader request accepted
//  ext_cmd_addr    in   AW     byte address
//  ext_cmd_read    in   1      1=read, 0=write
//  ext_cmd_wdata   in   DW     write data
//  ext_cmd_wmask   in   DW/8   byte enables
//  ext_rsp_valid   out  1      response valid (reads and writes)
//  ext_rsp_ready   in   1      loader consumes response
//  ext_rsp_rdata   out  DW     read data; 0 for writes
//  ext_rsp_err     out  1      address out of range
//  itcm_nohold     out  1      1 = SRAM output no longer holds the last IFU fetch
// BEHAVIOUR
//  Reset: all *_rsp_valid=0, *_rsp_err=0, rdata=0, itcm_nohold=1, rr pointer=IFU-next. SRAM contents not reset.
//  Accept rule, port p: cmd_ready_p = grant_p & (!rsp_valid_p | rsp_ready_p). Combinational in valid/ready.
//  Arbiter: both valid -> grant alternates, last_grant updated only on accepted cmd. One valid -> grant it.
//  Loser keeps cmd_ready=0 and must hold its cmd stable.
//  Latency: cmd accepted cycle N -> rsp_valid_p=1 in cycle N+1 with data. Throughput 1/cycle/port while rsp_ready=1.
//  Hold: rsp_valid&!rsp_ready -> rdata/err frozen in a per-port hold reg; valid stays 1 until ready.
//  The SRAM may then serve the other port.
//  Per-port FSM: IDLE -(accept)-> RSP. RSP -(ready & accept)-> RSP. RSP -(ready & !accept)-> IDLE.
//  RSP -(!ready)-> RSP (held).
//  Write: SRAM bytes with wmask=1 updated at posedge of accept. rsp next cycle with rdata=0, err=0.
//  wmask=0 is legal; it is a no-op write that still responds.
//  Out of range (word index >= DEPTH): no SRAM enable, rsp err=1, rdata=0, same 1-cycle latency.
//  nohold: 0 the cycle after an in-range IFU read.
//  nohold: 1 the cycle after any EXT access or any cycle with SRAM disabled while no IFU rsp is held.
//  Same-address EXT write then IFU read in the next cycle: read returns new data (no bypass needed, 1RW sequential).
//  rst mid-transaction: pending responses dropped, valids 0 next cycle, an in-flight write may or may not land.
// STRUCTURE
//  Widths/defaults from `QPU_ITCM_ADDR_WIDTH / `QPU_ITCM_DATA_WIDTH in QPU_defines.v.
//  Add `QPU_ITCM_RAM_DEPTH there.
//  Sub-module qpu_itcm_sram_1rw: behavioural DEPTHxDW, byte-enable write, registered read (cs, we, wem, addr, din, dout).
//  Arbiter, per-port FSM and hold regs inline.
// TESTING
//  1. IFU reads 0x0,0x8,0x10 back-to-back, ready=1 -> 3 rsp in cycles N+1..N+3, data = preloaded words, nohold=0.
//  2. EXT writes 0x20 = 0xDEADBEEF_01234567, wmask=0x0F, over 0xFFFF... -> reads back 0xFFFFFFFF_01234567.
//  3. Both valid for 4 cycles -> grants alternate IFU, EXT, IFU, EXT (start IFU after reset).
//     Each port gets rsp one cycle after its accept.
//  4. IFU rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable.
//     EXT still served meanwhile. ifu_cmd_ready=0 until ready rises.
//  5. Address 0x1_0000 with AW=17, DEPTH=8192 -> err=1, rdata=0, SRAM cs never asserted.
//  6. rst=1 while IFU rsp held -> next cycle rsp_valid=0, nohold=1. First fetch after reset responds normally.

Source files
------------

// File: rtl/qpu_itcm_ctrl_pkg.sv
// Purpose : shared widths, state encodings and the word range helper for the ITCM controller.
// Latency : n/a (definitions only).
// Backpressure: n/a.
// Contents: default address/data widths and RAM depth, per-port response state, arbiter port id.
package qpu_itcm_ctrl_pkg;

  localparam int QPU_ITCM_ADDR_WIDTH = 16;
  localparam int QPU_ITCM_DATA_WIDTH = 64;
  localparam int QPU_ITCM_RAM_DEPTH  =
    2 ** (QPU_ITCM_ADDR_WIDTH - $clog2(QPU_ITCM_DATA_WIDTH / 8));

  // Per-port response state: RSP means rsp_valid is asserted.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } rsp_state_e;

  // Arbiter port identity, also used as the last-grant record.
  typedef enum logic {
    PORT_IFU = 1'b0,
    PORT_EXT = 1'b1
  } port_e;

  // A word index is served only when it lands inside the physical array.
  function automatic logic word_in_range(input logic [31:0] widx, input int unsigned depth);
    return widx < depth;
  endfunction

endpackage

// File: rtl/qpu_itcm_sram_1rw.sv
// Purpose : behavioural single-port DEPTHxDW SRAM with byte-enable writes and a registered read port.
// Latency : read data valid on dout one cycle after cs&!we; dout holds its value otherwise.
// Backpressure: none, one access per cycle when cs is high.
// Ports   : clk; cs chip select; we write enable; wem byte enables; addr word address;
//           din write data; dout registered read data.
module qpu_itcm_sram_1rw #(
  parameter int DW    = 64,
  parameter int DEPTH = 8192,
  parameter int RAW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic [DW/8-1:0]   wem,
  input  logic [RAW-1:0]    addr,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int b = 0; b < DW / 8; b++) begin
          if (wem[b]) begin
            r_mem[addr][b*8 +: 8] <= din[b*8 +: 8];
          end
        end
      end else begin
        r_dout <= r_mem[addr];
      end
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/qpu_itcm_ctrl.sv
// Purpose : ITCM responder; round-robin arbitration of the IFU fetch port and EXT loader port into one 1RW SRAM.
// Latency : command accepted in cycle N -> response valid in cycle N+1; 1 command/cycle/port while rsp_ready=1.
// Backpressure: a stalled response is frozen in a per-port hold reg; that port's cmd_ready drops until rsp_ready.
// Ports   : clk, rst (sync, active-high); ifu_cmd_* / ifu_rsp_* read-only fetch port;
//           ext_cmd_* / ext_rsp_* read/write loader port; itcm_nohold tells the IFU the SRAM output was disturbed.
module qpu_itcm_ctrl
  import qpu_itcm_ctrl_pkg::*;
#(
  parameter int AW    = QPU_ITCM_ADDR_WIDTH,
  parameter int DW    = QPU_ITCM_DATA_WIDTH,
  parameter int DEPTH = 2 ** (AW - $clog2(DW / 8))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_cmd_valid,
  output logic              ifu_cmd_ready,
  input  logic [AW-1:0]     ifu_cmd_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DW-1:0]     ifu_rsp_rdata,
  output logic              ifu_rsp_err,
  input  logic              ext_cmd_valid,
  output logic              ext_cmd_ready,
  input  logic [AW-1:0]     ext_cmd_addr,
  input  logic              ext_cmd_read,
  input  logic [DW-1:0]     ext_cmd_wdata,
  input  logic [DW/8-1:0]   ext_cmd_wmask,
  output logic              ext_rsp_valid,
  input  logic              ext_rsp_ready,
  output logic [DW-1:0]     ext_rsp_rdata,
  output logic              ext_rsp_err,
  output logic              itcm_nohold
);

  localparam int BW   = DW / 8;
  localparam int OFFW = $clog2(BW);
  localparam int WIW  = AW - OFFW;
  localparam int RAW  = $clog2(DEPTH);

  // ---------------- address decode ----------------
  logic [WIW-1:0] w_ifu_widx;
  logic [WIW-1:0] w_ext_widx;
  logic           w_ifu_inrange;
  logic           w_ext_inrange;
  logic           w_unused_lsb;

  assign w_ifu_widx    = ifu_cmd_addr[AW-1:OFFW];
  assign w_ext_widx    = ext_cmd_addr[AW-1:OFFW];
  assign w_ifu_inrange = word_in_range(32'(w_ifu_widx), DEPTH);
  assign w_ext_inrange = word_in_range(32'(w_ext_widx), DEPTH);
  assign w_unused_lsb  = ^{ifu_cmd_addr[OFFW-1:0], ext_cmd_addr[OFFW-1:0]};

  // ---------------- arbitration ----------------
  rsp_state_e r_ifu_state;
  rsp_state_e r_ext_state;
  port_e      r_last_grant;
  logic       w_ifu_elig;
  logic       w_ext_elig;
  logic       w_ifu_acc;
  logic       w_ext_acc;

  // Only ports whose response slot can be refilled compete, so a port stalled on
  // rsp_ready never blocks the other one from the SRAM.
  assign w_ifu_elig = ifu_cmd_valid & ((r_ifu_state == ST_IDLE) | ifu_rsp_ready);
  assign w_ext_elig = ext_cmd_valid & ((r_ext_state == ST_IDLE) | ext_rsp_ready);
  assign w_ifu_acc  = w_ifu_elig & (!w_ext_elig | (r_last_grant == PORT_EXT));
  assign w_ext_acc  = w_ext_elig & !w_ifu_acc;

  assign ifu_cmd_ready = w_ifu_acc;
  assign ext_cmd_ready = w_ext_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT_EXT;  // IFU wins the first contended cycle
    end else if (w_ifu_acc) begin
      r_last_grant <= PORT_IFU;
    end else if (w_ext_acc) begin
      r_last_grant <= PORT_EXT;
    end
  end

  // ---------------- SRAM ----------------
  logic             w_sram_cs;
  logic             w_sram_we;
  logic [BW-1:0]    w_sram_wem;
  logic [RAW-1:0]   w_sram_addr;
  logic [DW-1:0]    w_sram_dout;

  // Out-of-range accesses never enable the array.
  assign w_sram_cs   = (w_ifu_acc & w_ifu_inrange) | (w_ext_acc & w_ext_inrange);
  assign w_sram_we   = w_ext_acc & !ext_cmd_read;
  assign w_sram_wem  = w_sram_we ? ext_cmd_wmask : '0;
  assign w_sram_addr = w_ext_acc ? w_ext_widx[RAW-1:0] : w_ifu_widx[RAW-1:0];

  qpu_itcm_sram_1rw #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) u_sram (
    .clk  (clk),
    .cs   (w_sram_cs),
    .we   (w_sram_we),
    .wem  (w_sram_wem),
    .addr (w_sram_addr),
    .din  (ext_cmd_wdata),
    .dout (w_sram_dout)
  );

  // ---------------- IFU response FSM ----------------
  // r_*_fresh: response is in its first cycle, data still sits on the SRAM output.
  // r_*_rd   : response carries SRAM read data (in-range read); otherwise rdata is 0.
  logic          r_ifu_fresh;
  logic          r_ifu_rd;
  logic          r_ifu_err;
  logic [DW-1:0] r_ifu_hold;
  logic [DW-1:0] w_ifu_dat;

  assign w_ifu_dat = r_ifu_fresh ? (r_ifu_rd ? w_sram_dout : '0) : r_ifu_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifu_state <= ST_IDLE;
      r_ifu_fresh <= 1'b0;
      r_ifu_rd    <= 1'b0;
      r_ifu_err   <= 1'b0;
      r_ifu_hold  <= '0;
    end else if (w_ifu_acc) begin
      r_ifu_state <= ST_RSP;
      r_ifu_fresh <= 1'b1;
      r_ifu_rd    <= w_ifu_inrange;
      r_ifu_err   <= !w_ifu_inrange;
    end else if (r_ifu_state == ST_RSP) begin
      if (ifu_rsp_ready) begin
        r_ifu_state <= ST_IDLE;
        r_ifu_fresh <= 1'b0;
        r_ifu_rd    <= 1'b0;
        r_ifu_err   <= 1'b0;
        r_ifu_hold  <= '0;
      end else if (r_ifu_fresh) begin
        // Capture before the SRAM is handed to the other port.
        r_ifu_hold  <= w_ifu_dat;
        r_ifu_fresh <= 1'b0;
      end
    end
  end

  assign ifu_rsp_valid = (r_ifu_state == ST_RSP);
  assign ifu_rsp_rdata = w_ifu_dat;
  assign ifu_rsp_err   = r_ifu_err;

  // ---------------- EXT response FSM ----------------
  logic          r_ext_fresh;
  logic          r_ext_rd;
  logic          r_ext_err;
  logic [DW-1:0] r_ext_hold;
  logic [DW-1:0] w_ext_dat;

  assign w_ext_dat = r_ext_fresh ? (r_ext_rd ? w_sram_dout : '0) : r_ext_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_state <= ST_IDLE;
      r_ext_fresh <= 1'b0;
      r_ext_rd    <= 1'b0;
      r_ext_err   <= 1'b0;
      r_ext_hold  <= '0;
    end else if (w_ext_acc) begin
      r_ext_state <= ST_RSP;
      r_ext_fresh <= 1'b1;
      r_ext_rd    <= ext_cmd_read & w_ext_inrange;  // writes answer with rdata=0
      r_ext_err   <= !w_ext_inrange;
    end else if (r_ext_state == ST_RSP) begin
      if (ext_rsp_ready) begin
        r_ext_state <= ST_IDLE;
        r_ext_fresh <= 1'b0;
        r_ext_rd    <= 1'b0;
        r_ext_err   <= 1'b0;
        r_ext_hold  <= '0;
      end else if (r_ext_fresh) begin
        r_ext_hold  <= w_ext_dat;
        r_ext_fresh <= 1'b0;
      end
    end
  end

  assign ext_rsp_valid = (r_ext_state == ST_RSP);
  assign ext_rsp_rdata = w_ext_dat;
  assign ext_rsp_err   = r_ext_err;

  // ---------------- nohold ----------------
  // Cleared only when the SRAM output register carries the latest IFU fetch;
  // an idle SRAM keeps its output but the IFU no longer owns it unless it is
  // still holding a response.
  logic r_nohold;
  logic w_ifu_held;

  assign w_ifu_held = (r_ifu_state == ST_RSP) & !ifu_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nohold <= 1'b1;
    end else if (w_ifu_acc && w_ifu_inrange) begin
      r_nohold <= 1'b0;
    end else if (w_ext_acc) begin
      r_nohold <= 1'b1;
    end else if (!w_sram_cs && !w_ifu_held) begin
      r_nohold <= 1'b1;
    end
  end

  assign itcm_nohold = r_nohold;

endmodule

// File: tb/tb_qpu_itcm_ctrl.sv
// Purpose : self-checking bench for qpu_itcm_ctrl (AW=17, DEPTH=8192 so 0x1_0000 is out of range).
// Latency : responses are matched against a per-port expectation queue filled on command accept.
// Backpressure: rsp_ready is driven per test; stalled responses are checked for stability.
module tb_qpu_itcm_ctrl;

  localparam int AW    = 17;
  localparam int DW    = 64;
  localparam int DEPTH = 8192;

  localparam logic [DW-1:0] A0   = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] A1   = 64'h1122_3344_5566_7788;
  localparam logic [DW-1:0] A2   = 64'hCAFE_F00D_0BAD_BEEF;
  localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] MIX  = 64'hFFFF_FFFF_0123_4567;
  localparam logic [DW-1:0] PART = 64'hAABB_3344_5566_0011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ifu_cmd_valid, ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [AW-1:0]   ifu_cmd_addr;
  logic [DW-1:0]   ifu_rsp_rdata;
  logic            ext_cmd_valid, ext_cmd_ready, ext_cmd_read, ext_rsp_valid, ext_rsp_ready, ext_rsp_err;
  logic [AW-1:0]   ext_cmd_addr;
  logic [DW-1:0]   ext_cmd_wdata, ext_rsp_rdata;
  logic [DW/8-1:0] ext_cmd_wmask;
  logic            itcm_nohold;

  always #5 clk = ~clk;

  qpu_itcm_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_cmd_valid (ifu_cmd_valid),
    .ifu_cmd_ready (ifu_cmd_ready),
    .ifu_cmd_addr  (ifu_cmd_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .ifu_rsp_err   (ifu_rsp_err),
    .ext_cmd_valid (ext_cmd_valid),
    .ext_cmd_ready (ext_cmd_ready),
    .ext_cmd_addr  (ext_cmd_addr),
    .ext_cmd_read  (ext_cmd_read),
    .ext_cmd_wdata (ext_cmd_wdata),
    .ext_cmd_wmask (ext_cmd_wmask),
    .ext_rsp_valid (ext_rsp_valid),
    .ext_rsp_ready (ext_rsp_ready),
    .ext_rsp_rdata (ext_rsp_rdata),
    .ext_rsp_err   (ext_rsp_err),
    .itcm_nohold   (itcm_nohold)
  );

  typedef struct {
    bit              to_ext;
    bit              rd;
    bit              drain;
    bit              chk;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic [DW-1:0]   exp_rdata;
    bit              exp_err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
    int            acc;
    bit            chk;
  } exp_t;

  vec_t ifu_q[$];
  vec_t ext_q[$];
  exp_t ifu_sb[$];
  exp_t ext_sb[$];
  bit   gnt_log[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cs_hits = 0;
  bit   watch_cs = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input bit to_ext, input bit rd, input bit drain, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW/8-1:0] wmask,
                              input logic [DW-1:0] exp_rdata, input bit exp_err);
    vec_t v;
    v.to_ext = to_ext; v.rd = rd; v.drain = drain; v.chk = 1'b1; v.addr = addr;
    v.wdata = wdata; v.wmask = wmask; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // IFU command driver: presents the queue head at negedge, sees acceptance just before posedge.
  initial begin
    ifu_cmd_valid = 1'b0;
    ifu_cmd_addr  = '0;
    forever begin
      @(negedge clk);
      if (!rst && ifu_q.size() > 0) begin
        ifu_cmd_valid = 1'b1;
        ifu_cmd_addr  = ifu_q[0].addr;
      end else begin
        ifu_cmd_valid = 1'b0;
      end
      #4;
      if (!rst && ifu_cmd_valid && ifu_cmd_ready) begin
        exp_t e;
        e.rdata = ifu_q[0].exp_rdata; e.err = ifu_q[0].exp_err; e.acc = cyc; e.chk = ifu_q[0].chk;
        ifu_sb.push_back(e);
        gnt_log.push_back(1'b0);
        void'(ifu_q.pop_front());
      end
    end
  end

  // EXT command driver.
  initial begin
    ext_cmd_valid = 1'b0;
    ext_cmd_addr  = '0;
    ext_cmd_read  = 1'b0;
    ext_cmd_wdata = '0;
    ext_cmd_wmask = '0;
    forever begin
      @(negedge clk);
      if (!rst && ext_q.size() > 0) begin
        ext_cmd_valid = 1'b1;
        ext_cmd_addr  = ext_q[0].addr;
        ext_cmd_read  = ext_q[0].rd;
        ext_cmd_wdata = ext_q[0].wdata;
        ext_cmd_wmask = ext_q[0].wmask;
      end else begin
        ext_cmd_valid = 1'b0;
      end
      #4;
      if (!rst && ext_cmd_valid && ext_cmd_ready) begin
        exp_t e;
        e.rdata = ext_q[0].exp_rdata; e.err = ext_q[0].exp_err; e.acc = cyc; e.chk = ext_q[0].chk;
        ext_sb.push_back(e);
        gnt_log.push_back(1'b1);
        void'(ext_q.pop_front());
      end
    end
  end

  // Response monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (ifu_rsp_valid && ifu_rsp_ready) begin
        if (ifu_sb.size() == 0) begin
          chk("ifu_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = ifu_sb.pop_front();
          chk("ifu_rdata", ifu_rsp_rdata, e.rdata);
          chk("ifu_err", 64'(ifu_rsp_err), 64'(e.err));
          if (e.chk) begin
            chk("ifu_latency", 64'(cyc - e.acc), 64'd1);
            if (!e.err) chk("ifu_nohold", 64'(itcm_nohold), 64'd0);
          end
        end
      end
      if (ext_rsp_valid && ext_rsp_ready) begin
        if (ext_sb.size() == 0) begin
          chk("ext_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = ext_sb.pop_front();
          chk("ext_rdata", ext_rsp_rdata, e.rdata);
          chk("ext_err", 64'(ext_rsp_err), 64'(e.err));
          if (e.chk) chk("ext_latency", 64'(cyc - e.acc), 64'd1);
        end
      end
      if (watch_cs && dut.w_sram_cs) cs_hits++;
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((ifu_q.size() + ext_q.size() + ifu_sb.size() + ext_sb.size()) != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_within_budget", 64'(t < 100), 64'd1);
  endtask

  task automatic flush_all();
    ifu_q.delete(); ext_q.delete(); ifu_sb.delete(); ext_sb.delete(); gnt_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  vec_t vecs[15];

  initial begin
    int t;
    vec_t v;
    ifu_rsp_ready = 1'b1;
    ext_rsp_ready = 1'b1;

    // preload, back-to-back fetches, masked writes, wmask=0 no-op write
    vecs[0]  = mk(1, 0, 0, 17'h00000, A0,   8'hFF, '0,   0);
    vecs[1]  = mk(1, 0, 0, 17'h00008, A1,   8'hFF, '0,   0);
    vecs[2]  = mk(1, 0, 0, 17'h00010, A2,   8'hFF, '0,   0);
    vecs[3]  = mk(1, 0, 0, 17'h00020, ONES, 8'hFF, '0,   0);
    vecs[4]  = mk(0, 1, 1, 17'h00000, '0,   8'h00, A0,   0);
    vecs[5]  = mk(0, 1, 0, 17'h00008, '0,   8'h00, A1,   0);
    vecs[6]  = mk(0, 1, 0, 17'h00010, '0,   8'h00, A2,   0);
    vecs[7]  = mk(1, 0, 1, 17'h00020, 64'hDEAD_BEEF_0123_4567, 8'h0F, '0, 0);
    vecs[8]  = mk(1, 1, 0, 17'h00020, '0,   8'h00, MIX,  0);
    vecs[9]  = mk(0, 1, 0, 17'h00020, '0,   8'h00, MIX,  0);
    vecs[10] = mk(1, 0, 1, 17'h00020, 64'h0, 8'h00, '0,  0);
    vecs[11] = mk(1, 1, 0, 17'h00020, '0,   8'h00, MIX,  0);
    vecs[12] = mk(1, 0, 0, 17'h00030, A1,   8'hFF, '0,   0);
    vecs[13] = mk(1, 0, 0, 17'h00030, 64'hAABB_CCDD_EEFF_0011, 8'hC3, '0, 0);
    vecs[14] = mk(0, 1, 1, 17'h00030, '0,   8'h00, PART, 0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("rst_ext_rsp_valid", 64'(ext_rsp_valid), 64'd0);
    chk("rst_ifu_rdata", ifu_rsp_rdata, 64'd0);
    chk("rst_ext_rdata", ext_rsp_rdata, 64'd0);
    chk("rst_ifu_err", 64'(ifu_rsp_err), 64'd0);
    chk("rst_ext_err", 64'(ext_rsp_err), 64'd0);
    chk("rst_nohold", 64'(itcm_nohold), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].drain) wait_drain();
      if (vecs[i].to_ext) ext_q.push_back(vecs[i]);
      else                ifu_q.push_back(vecs[i]);
    end
    wait_drain();

    // EXT write followed by an IFU fetch of the same word in the next cycle
    ext_q.push_back(mk(1, 0, 0, 17'h00038, 64'h5A5A_0F0F_A5A5_F0F0, 8'hFF, '0, 0));
    t = 0;
    while (ext_q.size() != 0 && t < 50) begin @(posedge clk); t++; end
    chk("wr_then_rd_accept", 64'(t < 50), 64'd1);
    ifu_q.push_back(mk(0, 1, 0, 17'h00038, '0, 8'h00, 64'h5A5A_0F0F_A5A5_F0F0, 0));
    wait_drain();

    // round-robin from reset: IFU, EXT, IFU, EXT
    @(negedge clk); rst = 1'b1; flush_all();
    repeat (2) @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ifu_q.push_back(mk(0, 1, 0, 17'h00000, '0, 8'h00, A0,  0));
    ifu_q.push_back(mk(0, 1, 0, 17'h00010, '0, 8'h00, A2,  0));
    ext_q.push_back(mk(1, 1, 0, 17'h00008, '0, 8'h00, A1,  0));
    ext_q.push_back(mk(1, 1, 0, 17'h00020, '0, 8'h00, MIX, 0));
    wait_drain();
    chk("grant_count", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) chk($sformatf("grant_order_%0d", i), 64'(gnt_log[i]), 64'(i % 2));
    end

    // IFU response stalled for 5 cycles while EXT keeps being served
    @(negedge clk); ifu_rsp_ready = 1'b0;
    @(posedge clk); #1;
    v = mk(0, 1, 0, 17'h00000, '0, 8'h00, A0, 0); v.chk = 0; ifu_q.push_back(v);
    v = mk(0, 1, 0, 17'h00008, '0, 8'h00, A1, 0); v.chk = 0; ifu_q.push_back(v);
    ext_q.push_back(mk(1, 1, 0, 17'h00010, '0, 8'h00, A2,  0));
    ext_q.push_back(mk(1, 1, 0, 17'h00020, '0, 8'h00, MIX, 0));
    ext_q.push_back(mk(1, 1, 0, 17'h00000, '0, 8'h00, A0,  0));
    t = 0;
    while (!ifu_rsp_valid && t < 20) begin @(negedge clk); #4; t++; end
    chk("hold_rsp_seen", 64'(ifu_rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_valid_%0d", i), 64'(ifu_rsp_valid), 64'd1);
      chk($sformatf("hold_rdata_%0d", i), ifu_rsp_rdata, A0);
      chk($sformatf("hold_cmd_ready_%0d", i), 64'(ifu_cmd_ready), 64'd0);
      @(negedge clk); #4;
    end
    chk("hold_ext_served", 64'(ext_q.size() + ext_sb.size()), 64'd0);
    @(negedge clk); ifu_rsp_ready = 1'b1;
    wait_drain();

    // out-of-range accesses: err=1, rdata=0, SRAM never enabled
    watch_cs = 1'b1;
    ifu_q.push_back(mk(0, 1, 0, 17'h10000, '0,   8'h00, '0, 1));
    ifu_q.push_back(mk(0, 1, 0, 17'h1FFF8, '0,   8'h00, '0, 1));
    ext_q.push_back(mk(1, 1, 0, 17'h10000, '0,   8'h00, '0, 1));
    ext_q.push_back(mk(1, 0, 0, 17'h10000, ONES, 8'hFF, '0, 1));
    wait_drain();
    watch_cs = 1'b0;
    chk("oor_sram_cs_hits", 64'(cs_hits), 64'd0);
    ifu_q.push_back(mk(0, 1, 0, 17'h00000, '0, 8'h00, A0, 0));
    wait_drain();

    // reset while an IFU response is held
    @(negedge clk); ifu_rsp_ready = 1'b0;
    @(posedge clk); #1;
    v = mk(0, 1, 0, 17'h00010, '0, 8'h00, A2, 0); v.chk = 0; ifu_q.push_back(v);
    t = 0;
    while (!ifu_rsp_valid && t < 20) begin @(negedge clk); #4; t++; end
    chk("rst_hold_rsp_seen", 64'(ifu_rsp_valid), 64'd1);
    @(negedge clk); rst = 1'b1; flush_all();
    @(negedge clk);
    chk("rst_mid_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    chk("rst_mid_nohold", 64'(itcm_nohold), 64'd1);
    chk("rst_mid_ifu_rdata", ifu_rsp_rdata, 64'd0);
    rst = 1'b0;
    ifu_rsp_ready = 1'b1;
    ifu_q.push_back(mk(0, 1, 0, 17'h00008, '0, 8'h00, A1, 0));
    wait_drain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
